uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter between N_REQ requesters with round-robin arbitration and message locking. A granted requester keeps the transmitter until it sends the byte flagged last, so multi-byte messages are never interleaved. The block sits between the requesters and the transmitter's data/valid/ready interface. The transmitter samples valid on its rising edge, so every byte is issued as a single-cycle valid pulse. Completion is tracked through the ready fall and the ready rise.

Parameters:
N_REQ, 4, number of requesters (1..8)
BUSY_TIMEOUT, 8, cycles to wait for tx_ready to fall after a pulse before re-issuing it

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a byte pending; held until req_ready[i]
req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]; held until accepted
req_last  in  N_REQ  pending byte ends requester i's message
req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted
grant  out  N_REQ  one-hot current message owner; all-zero when unlocked
busy  out  1  state != IDLE or grant != 0
tx_data  out  8  byte to transmitter, stable from pulse until next acceptance
tx_valid  out  1  single-cycle issue pulse to transmitter
tx_ready  in  1  transmitter idle (high) / shifting (low)

Behaviour:
- Reset (async, rst_n=0): req_ready=0, grant=0, tx_valid=0, tx_data=8'h00, busy=0, rr pointer=0, state IDLE, timeout counter=0. Outputs clear without a clock edge.
- States: IDLE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- IDLE, grant=0: if tx_ready=1 and any req_valid is set, the winner is the first set bit scanning from rr pointer upward, modulo N_REQ. On the same edge the block registers:
  - grant = one-hot(winner)
  - req_ready[winner]=1 for one cycle
  - tx_data = the winner's byte
  - tx_valid=1 for one cycle
  - last_q = req_last[winner]
  - state -> WAIT_BUSY
- IDLE, grant!=0 (locked): only the owner is considered. On owner req_valid=1 and tx_ready=1, the block does the same acceptance with the owner's byte. Other requesters are ignored, even when the owner idles indefinitely.
- IDLE with tx_ready=0: no acceptance. This covers the case where the transmitter is still shifting after a reset.
- Latency: byte accepted and tx_valid pulsed on the first edge where the IDLE conditions hold.
- WAIT_BUSY: tx_valid=0.
  - tx_ready=0 -> WAIT_DONE, counter cleared.
  - Otherwise the counter increments. On reaching BUSY_TIMEOUT, tx_valid is re-pulsed for one cycle with the same tx_data, and the counter clears.
  - req_ready is never re-pulsed on a retry.
- WAIT_DONE: on tx_ready=1:
  - if last_q: grant=0 and rr pointer = (owner+1) mod N_REQ.
  - if not last_q: grant is kept.
  - In both cases state -> IDLE.
- Next byte pulse: earliest one cycle after WAIT_DONE exits (IDLE then accepts). This guarantees tx_valid was low in the prior cycle, so the transmitter's edge detect fires.
- At most one bit of req_ready is high in any cycle. req_ready and tx_valid are pulsed on the same edge, except on retries.
- The rr pointer changes only on message completion, so fairness is per message, not per byte.
- An owner deasserting req_valid mid-message holds the lock. No abort exists; only reset releases the lock.
- req_last sampled on a one-byte message: acquisition and release both happen within the same transaction.
- rr pointer wraps N_REQ-1 -> 0.

Test Plan:
1. Single message from req0 (0xA1, 0xB2, 0xC3 with last on 0xC3); UART model drops ready 2 cycles after the pulse and holds it low for 10 cycles -> three one-cycle tx_valid pulses with data A1, B2, C3 in order; req_ready[0] pulses three times; grant=0001 until the ready rise after C3, then 0000.
2. All 4 requesters each send a one-byte last message at the same time, twice back to back -> service order 0,1,2,3,0,1,2,3 (pointer wraps); grant is one-hot throughout.
3. Message lock: req1 sends a 2-byte message with a 20-cycle gap between bytes while req2 is pending -> grant stays 0010 through the gap; req2's first pulse comes only after req1's last byte completes.
4. Pointer start: after serving req2, req0 and req3 assert together -> req3 is granted first, then req0.
5. Timeout: tx_ready held high -> tx_valid re-pulses every BUSY_TIMEOUT+1 cycles with the same tx_data; req_ready stays 0 after the initial pulse.
6. Reset mid-operation:
   - rst_n low in WAIT_DONE -> grant, tx_valid and busy are 0 before the next edge.
   - After release with tx_ready=0 and req0 valid -> no pulse until tx_ready=1, then one pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ requesters.
// A granted requester keeps the transmitter until its last-flagged byte completes.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   req_ready_q, req_ready_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [PTR_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cand;
   logic               sel_found;
   logic [PTR_W-1:0]   sel_idx;
   logic [PTR_W-1:0]   rr_next;

   // First pending requester scanning upward from the rr pointer, wrapping at N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if ((32'(rr_q) + k) >= N_REQ) begin
            cand = PTR_W'(32'(rr_q) + k - N_REQ);
         end else begin
            cand = PTR_W'(32'(rr_q) + k);
         end
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign rr_next = (32'(owner_q) == (N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = 1'b0;
      req_ready_d = '0;
      sel_found   = 1'b0;
      sel_idx     = owner_q;

      case (state_q)
         IDLE: begin
            // A locked message only listens to its owner.
            if (grant_q != '0) begin
               sel_found = req_valid[owner_q];
               sel_idx   = owner_q;
            end else begin
               sel_found = win_found;
               sel_idx   = win_idx;
            end
            if (tx_ready && sel_found) begin
               grant_d     = N_REQ'(1) << sel_idx;
               req_ready_d = N_REQ'(1) << sel_idx;
               owner_d     = sel_idx;
               tx_data_d   = req_data[{sel_idx, 3'b000} +: 8];
               tx_valid_d  = 1'b1;
               last_d      = req_last[sel_idx];
               cnt_d       = '0;
               state_d     = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_ready) begin
               state_d = WAIT_DONE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
               // Transmitter never went busy: re-issue the same byte.
               tx_valid_d = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               state_d = IDLE;
               if (last_q) begin
                  grant_d = '0;
                  rr_d    = rr_next;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) || (grant_d != '0);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         req_ready_q <= '0;
         owner_q     <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         req_ready_q <= req_ready_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed message scenarios checked every cycle
// against a message-level model of ownership, service order and retry timing.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int BT = 8;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]  req_last = '0;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  grant;
   logic          busy;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b1;

   uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .busy      (busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      int         idx;
      logic [7:0] d;
      logic       last;
   } exp_t;

   exp_t expq[$];

   task automatic expect_byte(input int idx, input logic [7:0] d, input logic last);
      exp_t e;
      e.idx = idx; e.d = d; e.last = last;
      expq.push_back(e);
   endtask

   // Transmitter model: goes busy one cycle after it sees a pulse, stays busy 10 cycles.
   logic uart_auto = 1'b0;
   initial begin
      forever begin
         @(negedge CLK);
         if (uart_auto && tx_valid) begin
            @(negedge CLK);
            tx_ready = 1'b0;
            repeat (10) @(negedge CLK);
            tx_ready = 1'b1;
         end
      end
   end

   // Message-level model state.
   int   g_idx     = -1;
   logic lk        = 1'b0;
   logic in_flight = 1'b0;
   logic low_seen  = 1'b0;
   int   gap       = 0;
   logic prev_tv   = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int   tv_count  = 0;
   int   rr_count  = 0;

   initial begin : compare
      int   ai;
      logic acc, elig, exp_acc, exp_retry;
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (!rst_n) begin
            g_idx = -1; lk = 1'b0; in_flight = 1'b0; low_seen = 1'b0; gap = 0;
            prev_tv = 1'b0; prev_data = 8'h00; tv_count = 0; rr_count = 0;
         end else begin
            gap++;
            acc     = (req_ready != '0);
            elig    = lk ? req_valid[g_idx] : (req_valid != '0);
            exp_acc = !in_flight && tx_ready && elig;
            chk("accept", 32'(acc), 32'(exp_acc));
            if (acc) begin
               ai = 0;
               for (int i = 0; i < N; i++) if (req_ready[i]) ai = i;
               chk("ready_onehot", 32'($countones(req_ready)), 1);
               chk("valid_with_ready", 32'(tx_valid), 1);
               chk("valid_low_before", 32'(prev_tv), 0);
               chk("data_vs_req", 32'(tx_data), 32'(req_data[8*ai +: 8]));
               chk("accept_expected", 32'(expq.size() != 0), 1);
               if (expq.size() != 0) begin
                  e = expq.pop_front();
                  chk("accept_idx", 32'(ai), 32'(e.idx));
                  chk("accept_data", 32'(tx_data), 32'(e.d));
                  lk = !e.last;
               end else begin
                  lk = !req_last[ai];
               end
               g_idx = ai;
               in_flight = 1'b1; low_seen = 1'b0; gap = 0;
               rr_count++;
            end else if (in_flight) begin
               if (!tx_ready) low_seen = 1'b1;
               else if (low_seen) begin
                  in_flight = 1'b0;
                  if (!lk) g_idx = -1;
               end
               exp_retry = in_flight && !low_seen && (gap == BT + 1);
               chk("retry_pulse", 32'(tx_valid), 32'(exp_retry));
               if (exp_retry) gap = 0;
            end else begin
               chk("no_spurious_valid", 32'(tx_valid), 0);
            end
            chk("grant", 32'(grant), (g_idx >= 0) ? 32'(1 << g_idx) : 32'd0);
            chk("busy", 32'(busy), 32'(in_flight || (g_idx >= 0)));
            if (!acc) chk("data_stable", 32'(tx_data), 32'(prev_data));
            prev_data = tx_data;
            prev_tv   = tx_valid;
            if (tx_valid) tv_count++;
         end
      end
   end

   task automatic send_byte(input int idx, input logic [7:0] d, input logic last);
      int n;
      @(negedge CLK);
      req_valid[idx] = 1'b1;
      req_data[8*idx +: 8] = d;
      req_last[idx] = last;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!req_ready[idx] && n < 2000);
      if (!req_ready[idx]) chk("accept_timeout", 32'(idx), 32'hFF);
      req_valid[idx] = 1'b0;
   endtask

   task automatic do_reset();
      req_valid = '0; req_last = '0; req_data = '0;
      uart_auto = 1'b0; tx_ready = 1'b1;
      @(negedge CLK);
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      repeat (2) @(negedge CLK);
      expq.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 500) begin
         @(negedge CLK);
         n++;
      end
      chk({nm, "_idle"}, 32'(busy), 0);
      chk({nm, "_drained"}, 32'(expq.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      // Single three-byte message from req0.
      do_reset();
      uart_auto = 1'b1;
      expect_byte(0, 8'hA1, 1'b0);
      expect_byte(0, 8'hB2, 1'b0);
      expect_byte(0, 8'hC3, 1'b1);
      send_byte(0, 8'hA1, 1'b0);
      chk("t1_grant_locked", 32'(grant), 32'h1);
      send_byte(0, 8'hB2, 1'b0);
      send_byte(0, 8'hC3, 1'b1);
      wait_idle("t1");
      chk("t1_pulses", 32'(tv_count), 3);
      chk("t1_ready_pulses", 32'(rr_count), 3);
      chk("t1_grant_released", 32'(grant), 0);

      // Four simultaneous one-byte messages, two rounds: strict 0..3 rotation.
      do_reset();
      uart_auto = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++)
            expect_byte(i, 8'((r + 1) * 16 + i), 1'b1);
      fork
         begin send_byte(0, 8'h10, 1'b1); send_byte(0, 8'h20, 1'b1); end
         begin send_byte(1, 8'h11, 1'b1); send_byte(1, 8'h21, 1'b1); end
         begin send_byte(2, 8'h12, 1'b1); send_byte(2, 8'h22, 1'b1); end
         begin send_byte(3, 8'h13, 1'b1); send_byte(3, 8'h23, 1'b1); end
      join
      wait_idle("t2");
      chk("t2_pulses", 32'(tv_count), 8);

      // Message lock across a long inter-byte gap with another requester waiting.
      do_reset();
      uart_auto = 1'b1;
      expect_byte(1, 8'h31, 1'b0);
      expect_byte(1, 8'h32, 1'b1);
      expect_byte(2, 8'h41, 1'b1);
      fork
         begin
            send_byte(1, 8'h31, 1'b0);
            repeat (15) @(negedge CLK);
            chk("t3_grant_in_gap", 32'(grant), 32'h2);
            chk("t3_no_interleave", 32'(tv_count), 1);
            repeat (5) @(negedge CLK);
            send_byte(1, 8'h32, 1'b1);
         end
         send_byte(2, 8'h41, 1'b1);
      join
      wait_idle("t3");

      // Pointer advances past req2: req3 beats req0.
      do_reset();
      uart_auto = 1'b1;
      expect_byte(2, 8'h51, 1'b1);
      send_byte(2, 8'h51, 1'b1);
      wait_idle("t4a");
      expect_byte(3, 8'h63, 1'b1);
      expect_byte(0, 8'h60, 1'b1);
      fork
         send_byte(0, 8'h60, 1'b1);
         send_byte(3, 8'h63, 1'b1);
      join
      wait_idle("t4b");

      // Transmitter never goes busy: periodic re-issue, no extra req_ready.
      do_reset();
      tx_ready = 1'b1;
      expect_byte(3, 8'hE5, 1'b1);
      send_byte(3, 8'hE5, 1'b1);
      repeat (28) @(negedge CLK);
      chk("t5_pulses", 32'(tv_count), 4);
      chk("t5_ready_pulses", 32'(rr_count), 1);
      chk("t5_data_held", 32'(tx_data), 32'hE5);
      tx_ready = 1'b0;
      repeat (3) @(negedge CLK);
      tx_ready = 1'b1;
      wait_idle("t5");

      // Reset while the transmitter is shifting, then release with it still busy.
      do_reset();
      tx_ready = 1'b1;
      expect_byte(0, 8'h77, 1'b1);
      send_byte(0, 8'h77, 1'b1);
      tx_ready = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t6_busy_before", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_tx_valid", 32'(tx_valid), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      @(negedge CLK);
      rst_n = 1'b1;
      expect_byte(0, 8'h5A, 1'b1);
      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h5A;
      req_last[0] = 1'b1;
      repeat (5) @(negedge CLK);
      chk("t6_held_off", 32'(tv_count), 0);
      tx_ready = 1'b1;
      begin
         int n;
         n = 0;
         do begin
            @(negedge CLK);
            n++;
         end while (!req_ready[0] && n < 100);
         chk("t6_accepted", 32'(req_ready[0]), 1);
      end
      req_valid[0] = 1'b0;
      chk("t6_one_pulse", 32'(tv_count), 1);
      chk("t6_grant", 32'(grant), 32'h1);
      tx_ready = 1'b0;
      repeat (2) @(negedge CLK);
      tx_ready = 1'b1;
      wait_idle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
